// File: rtl/seq_divider.sv
// Multi-cycle signed divider: non-restoring shift/add-subtract on operand magnitudes,
// followed by a sign-correction cycle. Reports per-operation add/sub step counts.
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [CNT_W-1:0] total_add_ops,
  output logic [CNT_W-1:0] total_sub_ops
);

  localparam int unsigned IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] dvd;
  logic [IW-1:0]    iter;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;

  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  // Operand magnitudes; the most-negative value maps onto 2^(WIDTH-1) unsigned.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

  // One non-restoring step: shift {A,Q}, then subtract M if A was non-negative, else add.
  assign acc_sh  = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign acc_nx  = acc[WIDTH] ? (acc_sh + {1'b0, m}) : (acc_sh - {1'b0, m});
  assign rem_mag = acc[WIDTH] ? (acc[WIDTH-1:0] + m) : acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      q             <= '0;
      m             <= '0;
      dvd           <= '0;
      iter          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      zero_div      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero   <= 1'b0;
      total_add_ops <= '0;
      total_sub_ops <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q         <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r         <= dividend[WIDTH-1];
            zero_div      <= (divisor == '0);
            dvd           <= dividend;
            q             <= dvd_mag;
            m             <= dvs_mag;
            acc           <= '0;
            iter          <= '0;
            total_add_ops <= '0;
            total_sub_ops <= '0;
            busy          <= 1'b1;
            state         <= ITER;
          end
        end
        ITER: begin
          acc  <= acc_nx;
          q    <= {q[WIDTH-2:0], ~acc_nx[WIDTH]};
          iter <= iter + 1'b1;
          if (acc[WIDTH]) total_add_ops <= total_add_ops + 1'b1;
          else            total_sub_ops <= total_sub_ops + 1'b1;
          if (iter == IW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // Final restore of a negative partial remainder counts as an add step.
          if (acc[WIDTH]) total_add_ops <= total_add_ops + 1'b1;
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dvd;
          end else begin
            quotient  <= neg_q ? -q : q;
            remainder <= neg_r ? -rem_mag : rem_mag;
          end
          div_by_zero <= zero_div;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
